// File: rtl/lc3b_types.sv
`default_nettype none
// ============================================================================
// Module   : lc3b_types
// Purpose  : Shared LC-3b word type, fetch-stage state encoding and PC step.
// Revision : 1.0 - initial release
// ============================================================================
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    typedef enum logic [1:0] {
        FETCH_REQ    = 2'd0,
        FETCH_HOLD   = 2'd1,
        FETCH_SQUASH = 2'd2
    } fetch_state_t;

    localparam int LC3B_PC_STEP = 2;

endpackage
`default_nettype wire

// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage_if
// Purpose  : Instruction-memory read/resp bus between fetch stage and memory.
// Revision : 1.0 - initial release
// ============================================================================
interface fetch_stage_if;
    import lc3b_types::*;

    logic     imem_read;
    lc3b_word imem_address;
    lc3b_word imem_rdata;
    logic     imem_resp;

    modport master (
        output imem_read,
        output imem_address,
        input  imem_rdata,
        input  imem_resp
    );

    modport slave (
        input  imem_read,
        input  imem_address,
        output imem_rdata,
        output imem_resp
    );

endinterface
`default_nettype wire

// File: rtl/fetch_perf_counter.sv
`default_nettype none
// ============================================================================
// Module   : fetch_perf_counter
// Purpose  : 16-bit saturating event counter with asynchronous reset.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_perf_counter (
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic        i_inc,
    output logic [15:0]      o_count
);

    localparam logic [15:0] c_MAX = 16'hFFFF;

    logic [15:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_inc && (r_count != c_MAX)) begin
            r_count <= r_count + 16'd1;
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Purpose  : LC-3b instruction fetch: owns the PC, reads imem, buffers one
//            instruction for the IF/ID barrier, handles redirects/squash.
//            Optional performance counters under macro FETCH_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage
    import lc3b_types::*;
#(
    parameter lc3b_word RESET_PC = 16'h0000,
    parameter int       PC_STEP  = LC3B_PC_STEP
) (
    input  wire logic      clk,
    input  wire logic      reset,
    input  wire logic      stall,
    input  wire logic      redirect,
    input  wire lc3b_word  redirect_pc,
    fetch_stage_if.master  imem,
    output lc3b_word       ir_out,
    output lc3b_word       pc_out,
    output logic           valid_out
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]    perf_fetched,
    output logic [15:0]    perf_squashed
`endif
);

    localparam lc3b_word c_PC_STEP = lc3b_word'(PC_STEP);

    fetch_state_t r_state;
    fetch_state_t w_next_state;
    lc3b_word     r_pc;
    lc3b_word     r_pend_pc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= FETCH_REQ;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            FETCH_REQ: begin
                if (imem.imem_resp) begin
                    w_next_state = redirect ? FETCH_REQ : FETCH_HOLD;
                end else if (redirect) begin
                    w_next_state = FETCH_SQUASH;
                end
            end
            FETCH_HOLD: begin
                if (redirect || !stall) begin
                    w_next_state = FETCH_REQ;
                end
            end
            FETCH_SQUASH: begin
                if (imem.imem_resp) begin
                    w_next_state = FETCH_REQ;
                end
            end
            default: w_next_state = FETCH_REQ;
        endcase
    end

    always_comb begin
        imem.imem_read    = (r_state != FETCH_HOLD);
        imem.imem_address = r_pc;
    end

    // Datapath: the address register only moves once the outstanding read
    // has completed, so imem_address stays stable while imem_read is high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc      <= RESET_PC;
            r_pend_pc <= RESET_PC;
            ir_out    <= '0;
            pc_out    <= '0;
            valid_out <= 1'b0;
        end else begin
            case (r_state)
                FETCH_REQ: begin
                    if (imem.imem_resp) begin
                        if (redirect) begin
                            r_pc <= redirect_pc;
                        end else begin
                            ir_out    <= imem.imem_rdata;
                            pc_out    <= r_pc;
                            valid_out <= 1'b1;
                        end
                    end else if (redirect) begin
                        r_pend_pc <= redirect_pc;
                    end
                end
                FETCH_HOLD: begin
                    if (redirect) begin
                        valid_out <= 1'b0;
                        r_pc      <= redirect_pc;
                    end else if (!stall) begin
                        valid_out <= 1'b0;
                        r_pc      <= r_pc + c_PC_STEP;
                    end
                end
                FETCH_SQUASH: begin
                    if (imem.imem_resp) begin
                        r_pc <= redirect ? redirect_pc : r_pend_pc;
                    end else if (redirect) begin
                        r_pend_pc <= redirect_pc;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    logic w_accept;
    logic w_squash;

    assign w_accept = valid_out && !stall;
    assign w_squash = imem.imem_resp &&
                      (((r_state == FETCH_REQ) && redirect) || (r_state == FETCH_SQUASH));

    fetch_perf_counter u_perf_fetched (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (w_accept),
        .o_count (perf_fetched)
    );

    fetch_perf_counter u_perf_squashed (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (w_squash),
        .o_count (perf_squashed)
    );
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Purpose  : Directed, table-driven self-checking bench for fetch_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] ir_out;
    logic [15:0] pc_out;
    logic        valid_out;
`ifdef FETCH_PERF_EN
    logic [15:0] perf_fetched;
    logic [15:0] perf_squashed;
`endif

    int checks = 0;
    int errors = 0;

    fetch_stage_if imem_bus ();

    fetch_stage dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem        (imem_bus),
        .ir_out      (ir_out),
        .pc_out      (pc_out),
        .valid_out   (valid_out)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched  (perf_fetched),
        .perf_squashed (perf_squashed)
`endif
    );

    always #5 clk = ~clk;

    // Each record: outputs expected at this negedge, then inputs for the next edge.
    typedef struct {
        logic        e_read;
        logic [15:0] e_addr;
        logic        e_valid;
        logic [15:0] e_ir;
        logic [15:0] e_pc;
        logic        stall;
        logic        redirect;
        logic [15:0] rpc;
        logic        resp;
        logic [15:0] rdata;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(logic er, logic [15:0] ea, logic ev, logic [15:0] ei,
                               logic [15:0] ep, logic st, logic rd, logic [15:0] rp,
                               logic rs, logic [15:0] dt);
        vec_t x;
        x.e_read = er; x.e_addr = ea; x.e_valid = ev; x.e_ir = ei; x.e_pc = ep;
        x.stall = st; x.redirect = rd; x.rpc = rp; x.resp = rs; x.rdata = dt;
        return x;
    endfunction

    task automatic check(input string name, input int idx, input logic [15:0] got,
                         input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, got, want);
        end
    endtask

    task automatic check_outs(input int idx, input logic er, input logic [15:0] ea,
                              input logic ev, input logic [15:0] ei, input logic [15:0] ep);
        check("imem_read",    idx, {15'd0, imem_bus.imem_read}, {15'd0, er});
        check("imem_address", idx, imem_bus.imem_address, ea);
        check("valid_out",    idx, {15'd0, valid_out}, {15'd0, ev});
        check("ir_out",       idx, ir_out, ei);
        check("pc_out",       idx, pc_out, ep);
    endtask

    initial begin
        //        read addr     vld ir       pc       stl rdr rpc      rsp rdata
        vecs.push_back(v(1, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000));
        vecs.push_back(v(1, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 1, 16'hA000));
        vecs.push_back(v(0, 16'h0000, 1, 16'hA000, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000));
        vecs.push_back(v(1, 16'h0002, 0, 16'hA000, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000));
        vecs.push_back(v(1, 16'h0002, 0, 16'hA000, 16'h0000, 0, 0, 16'h0000, 1, 16'hB002));
        vecs.push_back(v(0, 16'h0002, 1, 16'hB002, 16'h0002, 0, 0, 16'h0000, 0, 16'h0000));
        vecs.push_back(v(1, 16'h0004, 0, 16'hB002, 16'h0002, 0, 0, 16'h0000, 0, 16'h0000));
        vecs.push_back(v(1, 16'h0004, 0, 16'hB002, 16'h0002, 0, 0, 16'h0000, 1, 16'hC004));
        // Stalled HOLD for four edges
        vecs.push_back(v(0, 16'h0004, 1, 16'hC004, 16'h0004, 1, 0, 16'h0000, 0, 16'h0000));
        vecs.push_back(v(0, 16'h0004, 1, 16'hC004, 16'h0004, 1, 0, 16'h0000, 0, 16'h0000));
        vecs.push_back(v(0, 16'h0004, 1, 16'hC004, 16'h0004, 1, 0, 16'h0000, 0, 16'h0000));
        vecs.push_back(v(0, 16'h0004, 1, 16'hC004, 16'h0004, 1, 0, 16'h0000, 0, 16'h0000));
        vecs.push_back(v(0, 16'h0004, 1, 16'hC004, 16'h0004, 0, 0, 16'h0000, 0, 16'h0000));
        // Redirect during outstanding read, second redirect in SQUASH wins
        vecs.push_back(v(1, 16'h0006, 0, 16'hC004, 16'h0004, 0, 0, 16'h0000, 0, 16'h0000));
        vecs.push_back(v(1, 16'h0006, 0, 16'hC004, 16'h0004, 0, 1, 16'h1234, 0, 16'h0000));
        vecs.push_back(v(1, 16'h0006, 0, 16'hC004, 16'h0004, 0, 0, 16'h0000, 0, 16'h0000));
        vecs.push_back(v(1, 16'h0006, 0, 16'hC004, 16'h0004, 0, 1, 16'h2000, 0, 16'h0000));
        vecs.push_back(v(1, 16'h0006, 0, 16'hC004, 16'h0004, 0, 0, 16'h0000, 1, 16'hDEAD));
        vecs.push_back(v(1, 16'h2000, 0, 16'hC004, 16'h0004, 0, 0, 16'h0000, 1, 16'h1111));
        // Redirect in HOLD while stalled
        vecs.push_back(v(0, 16'h2000, 1, 16'h1111, 16'h2000, 1, 1, 16'h0040, 0, 16'h0000));
        vecs.push_back(v(1, 16'h0040, 0, 16'h1111, 16'h2000, 0, 0, 16'h0000, 1, 16'h2222));
        // Wrap: redirect to FFFE, accept, sequential next is 0000
        vecs.push_back(v(0, 16'h0040, 1, 16'h2222, 16'h0040, 0, 1, 16'hFFFE, 0, 16'h0000));
        vecs.push_back(v(1, 16'hFFFE, 0, 16'h2222, 16'h0040, 0, 0, 16'h0000, 1, 16'h3333));
        vecs.push_back(v(0, 16'hFFFE, 1, 16'h3333, 16'hFFFE, 0, 0, 16'h0000, 0, 16'h0000));
        // Redirect coincident with resp in REQ drops the data
        vecs.push_back(v(1, 16'h0000, 0, 16'h3333, 16'hFFFE, 0, 1, 16'h0100, 1, 16'h4444));
        vecs.push_back(v(1, 16'h0100, 0, 16'h3333, 16'hFFFE, 0, 0, 16'h0000, 0, 16'h0000));

        reset = 1'b1;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_pc = '0;
        imem_bus.imem_resp = 1'b0;
        imem_bus.imem_rdata = '0;

        repeat (2) @(negedge clk);
        check_outs(-1, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            check_outs(i, vecs[i].e_read, vecs[i].e_addr, vecs[i].e_valid,
                       vecs[i].e_ir, vecs[i].e_pc);
            stall               = vecs[i].stall;
            redirect            = vecs[i].redirect;
            redirect_pc         = vecs[i].rpc;
            imem_bus.imem_resp  = vecs[i].resp;
            imem_bus.imem_rdata = vecs[i].rdata;
            @(negedge clk);
        end

`ifdef FETCH_PERF_EN
        check("perf_fetched",  100, perf_fetched,  16'd5);
        check("perf_squashed", 100, perf_squashed, 16'd2);
`endif

        // Asynchronous reset asserted between edges while in HOLD
        imem_bus.imem_resp  = 1'b1;
        imem_bus.imem_rdata = 16'h5555;
        @(negedge clk);
        imem_bus.imem_resp = 1'b0;
        stall = 1'b1;
        check_outs(200, 1'b0, 16'h0100, 1'b1, 16'h5555, 16'h0100);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_outs(201, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000);
`ifdef FETCH_PERF_EN
        check("perf_fetched_rst",  201, perf_fetched,  16'd0);
        check("perf_squashed_rst", 201, perf_squashed, 16'd0);
`endif
        @(negedge clk);
        reset = 1'b0;
        stall = 1'b0;
        @(negedge clk);
        check_outs(202, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
